mem_arbiter: RTL

Byte-port memory arbiter and sequencer sitting between the instruction-fetch path, the load/store path and the single 8-bit RAM/IO bus of the core. Two requesters present whole-access requests: a 32-bit instruction fetch, or a 1/2/4-byte load or store. The arbiter grants one requester at a time and splits the access into pipelined byte transfers. Read bytes are assembled and sign-extended, and the arbiter returns a one-cycle done pulse with the result.

---
 rtl/mem_arbiter_if.sv | 27 ++
 rtl/mem_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester handshakes and 8-bit memory bus of the memory arbiter.
interface mem_arbiter_if #(parameter int ADDR_W = 32);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;
  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic              ls_signed;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_done;
  logic [31:0]       ls_rdata;
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata, mem_din,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata, mem_din,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants fetch or load/store to one 8-bit memory bus, splitting each access
// into pipelined byte transfers and assembling/sign-extending read data.
module mem_arbiter #(parameter int ADDR_W = 32) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          flush,
  mem_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;
  state_t state, state_nx;
  logic [2:0] n, issue_cnt, recv_cnt, ls_n;
  logic [31:0] asm_q, asm_nx, ls_ext, wsh;
  logic last_grant, if_elig, ls_elig, grant_if, grant_ls, last_rx, last_tx, st_done;
  logic [ADDR_W-1:0] busy_addr;
  // last_grant: 0 = fetch, 1 = load/store; a done output blocks its own requester for one edge
  always_comb begin
    if_elig = bus.if_req && !bus.if_done;
    ls_elig = bus.ls_req && !bus.ls_done;
    grant_ls = !flush && ls_elig && (!if_elig || !last_grant);
    grant_if = !flush && if_elig && !grant_ls;
    ls_n = bus.ls_size == 2'd0 ? 3'd1 : bus.ls_size == 2'd1 ? 3'd2 : 3'd4;
    busy_addr = state == IF_RD ? bus.if_addr : bus.ls_addr;
    last_rx = recv_cnt == n - 3'd1;
    last_tx = issue_cnt == n - 3'd1;
    asm_nx = asm_q | ({24'd0, bus.mem_din} << {recv_cnt[1:0], 3'd0});
    ls_ext = !bus.ls_signed ? asm_nx :
             bus.ls_size == 2'd0 ? {{24{asm_nx[7]}}, asm_nx[7:0]} :
             bus.ls_size == 2'd1 ? {{16{asm_nx[15]}}, asm_nx[15:0]} : asm_nx;
    wsh = bus.ls_wdata >> {issue_cnt[1:0], 3'd0};
    st_done = state == IDLE ? grant_ls && bus.ls_we && ls_n == 3'd1 : state == LS_WR && last_tx;
    state_nx = state;
    case (state)
      IDLE:    state_nx = grant_ls ? (!bus.ls_we ? LS_RD : ls_n == 3'd1 ? IDLE : LS_WR) :
                          grant_if ? IF_RD : IDLE;
      LS_WR:   state_nx = last_tx ? IDLE : LS_WR;
      default: state_nx = flush || last_rx ? IDLE : state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      n <= 3'd0;
      issue_cnt <= 3'd0;
      recv_cnt <= 3'd0;
      asm_q <= 32'd0;
      last_grant <= 1'b0;
      bus.if_done <= 1'b0;
      bus.if_data <= 32'd0;
      bus.ls_done <= 1'b0;
      bus.ls_rdata <= 32'd0;
      bus.mem_a <= '0;
      bus.mem_dout <= 8'd0;
      bus.mem_wr <= 1'b0;
    end else if (rdy) begin
      state <= state_nx;
      bus.if_done <= 1'b0;
      bus.ls_done <= 1'b0;
      if (state == IDLE) begin
        if (grant_ls || grant_if) begin
          n <= grant_ls ? ls_n : 3'd4;
          issue_cnt <= 3'd1;
          recv_cnt <= 3'd0;
          asm_q <= 32'd0;
          last_grant <= grant_ls;
          bus.mem_a <= grant_ls ? bus.ls_addr : bus.if_addr;
          bus.mem_wr <= grant_ls && bus.ls_we;
          bus.mem_dout <= grant_ls && bus.ls_we ? bus.ls_wdata[7:0] : 8'd0;
        end else begin
          bus.mem_a <= '0;
          bus.mem_wr <= 1'b0;
          bus.mem_dout <= 8'd0;
        end
      end else if (flush && state != LS_WR) begin
        bus.mem_a <= '0;
        bus.mem_wr <= 1'b0;
        bus.mem_dout <= 8'd0;
      end else begin
        if (issue_cnt < n) begin
          bus.mem_a <= busy_addr + ADDR_W'(issue_cnt);
          bus.mem_dout <= state == LS_WR ? wsh[7:0] : 8'd0;
          issue_cnt <= issue_cnt + 3'd1;
        end else begin
          bus.mem_a <= '0;
          bus.mem_wr <= 1'b0;
          bus.mem_dout <= 8'd0;
        end
        if (state != LS_WR) begin
          asm_q <= asm_nx;
          recv_cnt <= recv_cnt + 3'd1;
          if (last_rx && state == IF_RD) begin
            bus.if_done <= 1'b1;
            bus.if_data <= asm_nx;
          end
          if (last_rx && state == LS_RD) begin
            bus.ls_done <= 1'b1;
            bus.ls_rdata <= ls_ext;
          end
        end
      end
      if (st_done) begin
        bus.ls_done <= 1'b1;
        bus.ls_rdata <= 32'd0;
      end
    end
  end
endmodule
